i2c_byte_master: RTL and testbench
==================================

# i2c_byte_master

Synthesizable, command-driven I2C master that drives the same two-wire bus the slave bus-functional model answers on. It executes one bus primitive per command: START/repeated-START, WRITE byte, READ byte, or STOP. It returns the ACK bit or the read data through a one-cycle response pulse. It sits between a host register block and the open-drain SCL/SDA pads, and is exercised in the bench directly against the existing I2C slave model.

## Interface
- CLK_DIV, 250: system clocks per SCL quarter-period. SCL period = 4·CLK_DIV; 250 at 100 MHz gives 100 kHz. Legal range 2..65535.
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  block idle and able to accept a command
- cmd_i  in  2  command code (i2c_master_pkg::cmd_e)
- wdata_i  in  8  byte for WRITE, sampled at accept
- nack_i  in  1  for READ: 1 = master sends NACK after the byte, sampled at accept
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  8  byte received by READ; holds its value until the next READ completes
- rsp_ack_o  out  1  WRITE: 1 = slave ACKed (SDA sampled low)
- rsp_err_o  out  1  command illegal in the current bus state
- bus_owned_o  out  1  START issued, STOP not yet issued
- scl_i, sda_i  in  1  sampled pad levels
- scl_o, sda_o  out  1  open-drain drive: 0 = pull low, 1 = release

## Operation
- Commands: START=2'b00, WRITE=2'b01, READ=2'b10, STOP=2'b11.
- A command is accepted on a cycle where cmd_valid_i && cmd_ready_o. cmd_ready_o drops the next cycle.
- States: IDLE, HOLD (bus owned, SCL low), START, WRITE, READ, STOP, ERR.
- Each bus slot is 4 quarters, Q0..Q3, each CLK_DIV cycles long:
  - Q0: SCL=0, drive SDA.
  - Q1, Q2: SCL released.
  - Q3: SCL=0.
  - Sampling of sda_i happens on the last cycle of Q1.
- START:
  - From IDLE: Q0/Q1 SDA=1 SCL=1; Q2 SDA=0 SCL=1; Q3 SCL=0.
  - From HOLD (repeated START): Q0 SDA=1 SCL=0; Q1 SCL=1; Q2 SDA=0; Q3 SCL=0.
- WRITE: 8 slots, MSB first, then an ACK slot with SDA released. rsp_ack_o = ~sampled SDA.
- READ: 8 slots with SDA released, shifted MSB first, then an ACK slot driving SDA = nack_i.
- STOP: Q0 SDA=0 SCL=0; Q1 SCL=1; Q2 SDA=1; Q3 idle with both lines released. Ends in IDLE with bus_owned_o=0.
- Illegal commands go to ERR:
  - WRITE, READ, or STOP in IDLE;
  - START while a transfer is in progress (cannot occur, since ready is low).
- ERR behaviour: no bus activity; rsp_valid_o=1 and rsp_err_o=1 on the cycle after accept; back to the prior state.
- A NACKed WRITE still returns to HOLD. The host decides whether to STOP.
- Clock stretching: whenever SCL is released (Q1, Q2), the quarter counter freezes while scl_i==0. Counting resumes the cycle after scl_i reads 1.

## Timing
- Reset (asynchronous assert, synchronous release) drives:
  - outputs: scl_o=1, sda_o=1, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=8'h00, rsp_ack_o=0, rsp_err_o=0, bus_owned_o=0;
  - internal: state=IDLE, counters=0.
- Reset mid-transfer releases both lines immediately. No STOP is generated.
- Latency from accept to rsp_valid_o, without stretching:
  - START and STOP: 4·CLK_DIV+1 cycles;
  - WRITE and READ: 36·CLK_DIV+1 cycles;
  - ERR: 1 cycle.
- cmd_ready_o rises in the same cycle as rsp_valid_o. A command offered in that cycle is accepted, giving back-to-back commands with no idle slot.
- rsp_* fields other than rsp_data_o are valid only while rsp_valid_o=1. They are 0 otherwise.
- SDA changes only during Q0, or Q2 of START/STOP, so no data edge coincides with SCL high.

## Structure
- Package i2c_master_pkg holds:
  - cmd_e (2-bit command enum);
  - state_e;
  - localparam QUARTERS=4 and BITS_PER_XFER=9.
- Sub-module i2c_quarter_tick holds:
  - the 16-bit divide-by-CLK_DIV counter, a 2-bit quarter index, and the stretch freeze (scl released && !scl_i);
  - outputs: tick and quarter.
- The top holds the FSM, 4-bit slot counter, 8-bit shift register and response registers.

## Test plan
- CLK_DIV=4 throughout; slave model configured to address 0x22. The bench models a wired-AND bus: sda_i = sda_o & slave drive, scl_i = scl_o.
- START, WRITE 0x44, WRITE 0xA5, STOP → rsp_ack_o=1 twice; slave receive buffer = {0xA5}; bus_owned_o returns to 0; total 80·CLK_DIV+4 cycles.
- START, WRITE 0x45, READ nack=0, READ nack=1, STOP, with the slave transmit buffer preloaded {0x3C, 0xC3} → rsp_data_o = 0x3C, then 0xC3; sda_o=0 in the first read's ACK slot and 1 in the second.
- START, WRITE 0x7E (address with no slave) → rsp_ack_o=0; state HOLD; a following STOP completes normally.
- WRITE in IDLE → rsp_valid_o and rsp_err_o high on the cycle after accept; scl_o and sda_o stay 1 throughout.
- START, WRITE 0x44, repeated START, WRITE 0x45, with scl_i held low 10 extra cycles in one Q1 → START shape observed with SCL high; WRITE latency grows by exactly 10 cycles; slave sees RESTART.
- Assert rst_i=0 mid-WRITE (slot 3) → scl_o=sda_o=1 in the same cycle without a clock edge; cmd_ready_o=1 after release.

Source files
------------

// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the command-driven I2C byte master.
package i2c_master_pkg;

  localparam int unsigned QUARTERS      = 4;
  localparam int unsigned BITS_PER_XFER = 9;

  typedef enum logic [1:0] {
    CmdStart = 2'b00,
    CmdWrite = 2'b01,
    CmdRead  = 2'b10,
    CmdStop  = 2'b11
  } cmd_e;

  typedef logic [2:0] state_e;

  localparam state_e StIdle  = 3'd0;
  localparam state_e StHold  = 3'd1;
  localparam state_e StStart = 3'd2;
  localparam state_e StWrite = 3'd3;
  localparam state_e StRead  = 3'd4;
  localparam state_e StStop  = 3'd5;
  localparam state_e StErr   = 3'd6;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timebase: divide-by-CLK_DIV counter plus quarter index,
// frozen while a released SCL is still held low by another device.
module i2c_quarter_tick
  import i2c_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic       scl_rel,
  input  logic       scl_i,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam logic [15:0] CntMax  = 16'(CLK_DIV - 1);
  localparam logic [1:0]  LastQtr = 2'(QUARTERS - 1);

  logic [15:0] cnt_q;
  logic [1:0]  quarter_q;
  logic        freeze;

  assign freeze  = scl_rel & ~scl_i;
  assign tick    = en & ~freeze & (cnt_q == CntMax);
  assign quarter = quarter_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (!en) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (!freeze) begin
      if (tick) begin
        cnt_q     <= '0;
        quarter_q <= (quarter_q == LastQtr) ? 2'd0 : quarter_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Command-driven I2C master: one bus primitive (START, WRITE, READ, STOP) per
// accepted command, answered by a single-cycle response pulse.
module i2c_byte_master
  import i2c_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  input  logic       nack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_ack_o,
  output logic       rsp_err_o,
  output logic       bus_owned_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);

  state_e     state_q, state_d, prior_q, prior_d, base, go;
  logic [3:0] slot_q, slot_d;
  logic [7:0] shift_q, shift_d, rsp_data_q, rsp_data_d;
  logic       nack_q, nack_d, restart_q, restart_d, owned_q, owned_d, ack_q, ack_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_ack_q, rsp_ack_d, rsp_err_q, rsp_err_d;
  logic       tick, active, accept, sample, slot_end, last_slot, legal, scl_hi;
  logic [1:0] quarter;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en      (active),
    .scl_rel (scl_o),
    .scl_i   (scl_i),
    .tick    (tick),
    .quarter (quarter)
  );

  // ERR is a one-cycle detour; decisions are made against the state it came from.
  assign base        = (state_q == StErr) ? prior_q : state_q;
  assign cmd_ready_o = (state_q == StIdle) | (state_q == StHold) | (state_q == StErr);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign active      = (state_q == StStart) | (state_q == StWrite) |
                       (state_q == StRead)  | (state_q == StStop);
  assign sample      = tick & (quarter == 2'd1);
  assign slot_end    = tick & (quarter == 2'd3);
  assign last_slot   = (slot_q == 4'(BITS_PER_XFER - 1));
  assign scl_hi      = (quarter == 2'd1) | (quarter == 2'd2);

  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    case (base)
      StHold: begin
        scl_o = 1'b0;
        sda_o = 1'b0;
      end
      StStart: begin
        scl_o = scl_hi | ((quarter == 2'd0) & ~restart_q);
        sda_o = (quarter == 2'd0) | (quarter == 2'd1);
      end
      StWrite: begin
        scl_o = scl_hi;
        sda_o = last_slot ? 1'b1 : shift_q[7];
      end
      StRead: begin
        scl_o = scl_hi;
        sda_o = last_slot ? nack_q : 1'b1;
      end
      StStop: begin
        scl_o = (quarter != 2'd0);
        sda_o = (quarter == 2'd2) | (quarter == 2'd3);
      end
      default: ;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    go    = StErr;
    unique case (cmd_e'(cmd_i))
      CmdStart: begin legal = 1'b1;              go = StStart; end
      CmdWrite: begin legal = (base == StHold);  go = StWrite; end
      CmdRead:  begin legal = (base == StHold);  go = StRead;  end
      CmdStop:  begin legal = (base == StHold);  go = StStop;  end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prior_d     = prior_q;
    slot_d      = slot_q;
    shift_d     = shift_q;
    nack_d      = nack_q;
    restart_d   = restart_q;
    owned_d     = owned_q;
    ack_d       = ack_q;
    rsp_valid_d = 1'b0;
    rsp_ack_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;

    if (accept) begin
      slot_d = '0;
      if (legal) begin
        state_d = go;
        if (go == StStart) begin
          restart_d = (base == StHold);
          owned_d   = 1'b1;
        end
        if (go == StWrite) shift_d = wdata_i;
        if (go == StRead)  nack_d  = nack_i;
      end else begin
        state_d     = StErr;
        prior_d     = base;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    end else if (state_q == StErr) begin
      state_d = prior_q;
    end else if (slot_end) begin
      case (state_q)
        StStart: begin
          state_d     = StHold;
          rsp_valid_d = 1'b1;
        end
        StStop: begin
          state_d     = StIdle;
          owned_d     = 1'b0;
          rsp_valid_d = 1'b1;
        end
        StWrite, StRead: begin
          if (last_slot) begin
            state_d     = StHold;
            rsp_valid_d = 1'b1;
            if (state_q == StWrite) rsp_ack_d = ack_q;
            else                    rsp_data_d = shift_q;
          end else begin
            slot_d = slot_q + 4'd1;
            if (state_q == StWrite) shift_d = {shift_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end else if (sample) begin
      if (state_q == StRead && !last_slot) shift_d = {shift_q[6:0], sda_i};
      if (state_q == StWrite && last_slot) ack_d = ~sda_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      prior_q     <= StIdle;
      slot_q      <= '0;
      shift_q     <= '0;
      nack_q      <= 1'b0;
      restart_q   <= 1'b0;
      owned_q     <= 1'b0;
      ack_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      prior_q     <= prior_d;
      slot_q      <= slot_d;
      shift_q     <= shift_d;
      nack_q      <= nack_d;
      restart_q   <= restart_d;
      owned_q     <= owned_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_ack_o   = rsp_ack_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;
  assign bus_owned_o = owned_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed and randomized bench for i2c_byte_master against a behavioural
// I2C slave on a wired-AND bus.
module tb_i2c_byte_master;
  import i2c_master_pkg::*;

  localparam int D = 4;
  localparam logic [6:0] SlaveAddr = 7'h22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_r = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic nack = 1'b0;
  logic cmd_ready_o, rsp_valid_o, rsp_ack_o, rsp_err_o, bus_owned_o, scl_o, sda_o;
  logic [7:0] rsp_data_o;
  logic stretch = 1'b0;
  logic sl_sda = 1'b1;
  logic scl_bus, sda_bus;

  assign scl_bus = scl_o & ~stretch;
  assign sda_bus = sda_o & sl_sda;

  always #5 clk = ~clk;

  i2c_byte_master #(
    .CLK_DIV (D)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_i       (cmd_r),
    .wdata_i     (wdata),
    .nack_i      (nack),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_ack_o   (rsp_ack_o),
    .rsp_err_o   (rsp_err_o),
    .bus_owned_o (bus_owned_o),
    .scl_i       (scl_bus),
    .sda_i       (sda_bus),
    .scl_o       (scl_o),
    .sda_o       (sda_o)
  );

  // Behavioural slave: modes 0 ignore, 1 receive, 2 give ACK, 3 transmit, 4 master ACK.
  logic [7:0] sl_rx[$];
  logic [7:0] sl_tx[$];
  int n_start = 0, n_restart = 0, n_stop = 0;

  initial begin
    logic scl_p, sda_p, scl_c, sda_c, first, addressed, rw, sl_active, m_nack;
    logic [7:0] sh, txb;
    int cnt, mode;
    scl_p = 1'b1; sda_p = 1'b1; first = 1'b0; addressed = 1'b0; rw = 1'b0;
    sl_active = 1'b0; m_nack = 1'b1; sh = '0; txb = 8'hFF; cnt = 0; mode = 0;
    forever begin
      @(negedge clk);
      scl_c = scl_bus;
      sda_c = sda_bus;
      if (!rst_n) begin
        sl_active = 1'b0; mode = 0; sl_sda = 1'b1;
      end else if (scl_p && scl_c && sda_p && !sda_c) begin
        n_start++;
        if (sl_active) n_restart++;
        sl_active = 1'b1; first = 1'b1; mode = 1; cnt = 0; sl_sda = 1'b1;
      end else if (scl_p && scl_c && !sda_p && sda_c) begin
        if (sl_active) n_stop++;
        sl_active = 1'b0; mode = 0; sl_sda = 1'b1;
      end else if (sl_active && !scl_p && scl_c) begin
        if (mode == 1) begin sh = {sh[6:0], sda_c}; cnt++; end
        else if (mode == 3) cnt++;
        else if (mode == 4) m_nack = sda_c;
      end else if (sl_active && scl_p && !scl_c) begin
        case (mode)
          1: if (cnt == 8) begin
               if (first) begin
                 addressed = (sh[7:1] == SlaveAddr); rw = sh[0]; first = 1'b0;
               end else if (addressed && !rw) sl_rx.push_back(sh);
               if (addressed) begin sl_sda = 1'b0; mode = 2; end
               else mode = 0;
             end
          2: begin
               if (rw) begin
                 txb = (sl_tx.size() > 0) ? sl_tx.pop_front() : 8'hFF;
                 mode = 3; cnt = 0; sl_sda = txb[7];
               end else begin
                 mode = 1; cnt = 0; sl_sda = 1'b1;
               end
             end
          3: if (cnt == 8) begin sl_sda = 1'b1; mode = 4; end
             else sl_sda = txb[7-cnt];
          4: if (m_nack) begin mode = 0; sl_sda = 1'b1; end
             else begin
               txb = (sl_tx.size() > 0) ? sl_tx.pop_front() : 8'hFF;
               mode = 3; cnt = 0; sl_sda = txb[7];
             end
          default: ;
        endcase
      end
      scl_p = scl_c;
      sda_p = sda_c;
    end
  end

  int checks = 0;
  int errors = 0;
  int r_lat, total, s0, st0, rs0, n, m;
  logic r_ack, r_err, rdy1, ack_sda;
  logic [7:0] r_data, snap, b;
  logic [7:0] exp_q[$];
  logic [1:0] ic;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one command, wait for its response, capture per-quarter slot-0 line levels.
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic nk);
    int w;
    w = 0;
    while (!cmd_ready_o && w < 200) begin @(posedge clk); #1; w++; end
    check("ready_wait", {31'd0, cmd_ready_o}, 32'd1);
    cmd_r = c; wdata = wd; nack = nk; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    r_lat = 1; snap = '0; ack_sda = 1'bx; rdy1 = 1'b1;
    while (!rsp_valid_o && r_lat < 1000) begin
      if (r_lat == 1) rdy1 = cmd_ready_o;
      for (int q = 0; q < 4; q++)
        if (r_lat == 2 + D*q) begin snap[7-2*q] = scl_o; snap[6-2*q] = sda_o; end
      if (r_lat == 33*D + 2) ack_sda = sda_o;
      @(posedge clk); #1;
      r_lat++;
    end
    check("rsp_seen", {31'd0, rsp_valid_o}, 32'd1);
    r_ack = rsp_ack_o; r_err = rsp_err_o; r_data = rsp_data_o;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", {31'd0, scl_o}, 32'd1);
    check("rst_sda", {31'd0, sda_o}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_data", {24'd0, rsp_data_o}, 32'h00);
    check("rst_ack_err", {30'd0, rsp_ack_o, rsp_err_o}, 32'd0);
    check("rst_owned", {31'd0, bus_owned_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // START, WRITE 0x44, WRITE 0xA5, STOP back-to-back
    sl_rx.delete(); s0 = n_start; st0 = n_stop; total = 0;
    do_cmd(CmdStart, 8'h00, 1'b0); total += r_lat;
    check("t1_start_lat", r_lat, 4*D+1);
    check("t1_start_shape", {24'd0, snap}, 32'hF8);
    check("t1_ready_drop", {31'd0, rdy1}, 32'd0);
    check("t1_owned", {31'd0, bus_owned_o}, 32'd1);
    check("t1_start_err", {31'd0, r_err}, 32'd0);
    do_cmd(CmdWrite, 8'h44, 1'b0); total += r_lat;
    check("t1_wr_lat", r_lat, 36*D+1);
    check("t1_ack_addr", {31'd0, r_ack}, 32'd1);
    do_cmd(CmdWrite, 8'hA5, 1'b0); total += r_lat;
    check("t1_ack_data", {31'd0, r_ack}, 32'd1);
    do_cmd(CmdStop, 8'h00, 1'b0); total += r_lat;
    check("t1_stop_lat", r_lat, 4*D+1);
    check("t1_owned_end", {31'd0, bus_owned_o}, 32'd0);
    check("t1_total", total, 80*D+4);
    check("t1_rx_len", sl_rx.size(), 1);
    if (sl_rx.size() > 0) check("t1_rx_byte", {24'd0, sl_rx[0]}, 32'hA5);
    check("t1_starts", n_start - s0, 1);
    check("t1_stops", n_stop - st0, 1);

    // Reads with ACK then NACK
    sl_tx.delete(); sl_tx.push_back(8'h3C); sl_tx.push_back(8'hC3);
    do_cmd(CmdStart, 8'h00, 1'b0);
    do_cmd(CmdWrite, 8'h45, 1'b0);
    check("t2_ack_addr", {31'd0, r_ack}, 32'd1);
    do_cmd(CmdRead, 8'h00, 1'b0);
    check("t2_rd0_lat", r_lat, 36*D+1);
    check("t2_rd0_data", {24'd0, r_data}, 32'h3C);
    check("t2_rd0_acksda", {31'd0, ack_sda}, 32'd0);
    do_cmd(CmdRead, 8'h00, 1'b1);
    check("t2_rd1_data", {24'd0, r_data}, 32'hC3);
    check("t2_rd1_acksda", {31'd0, ack_sda}, 32'd1);
    do_cmd(CmdStop, 8'h00, 1'b0);
    check("t2_data_hold", {24'd0, rsp_data_o}, 32'hC3);

    // Address with no slave
    do_cmd(CmdStart, 8'h00, 1'b0);
    do_cmd(CmdWrite, 8'h7E, 1'b0);
    check("t3_nack", {31'd0, r_ack}, 32'd0);
    @(posedge clk); #1;
    check("t3_hold_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("t3_hold_owned", {31'd0, bus_owned_o}, 32'd1);
    check("t3_hold_scl", {31'd0, scl_o}, 32'd0);
    do_cmd(CmdStop, 8'h00, 1'b0);
    check("t3_stop_err", {31'd0, r_err}, 32'd0);
    check("t3_stop_owned", {31'd0, bus_owned_o}, 32'd0);

    // WRITE in IDLE is illegal
    do_cmd(CmdWrite, 8'h12, 1'b0);
    check("t4_err_lat", r_lat, 1);
    check("t4_err", {31'd0, r_err}, 32'd1);
    check("t4_lines", {30'd0, scl_o, sda_o}, 32'd3);
    @(posedge clk); #1;
    check("t4_pulse", {31'd0, rsp_valid_o}, 32'd0);
    check("t4_err_clr", {31'd0, rsp_err_o}, 32'd0);
    check("t4_lines2", {30'd0, scl_o, sda_o}, 32'd3);
    check("t4_idle", {30'd0, cmd_ready_o, bus_owned_o}, 32'd2);

    // Repeated START, then a stretched WRITE
    rs0 = n_restart; sl_tx.delete();
    do_cmd(CmdStart, 8'h00, 1'b0);
    do_cmd(CmdWrite, 8'h44, 1'b0);
    do_cmd(CmdStart, 8'h00, 1'b0);
    check("t5_rs_shape", {24'd0, snap}, 32'h78);
    fork
      do_cmd(CmdWrite, 8'h45, 1'b0);
      begin
        int seen;
        logic prev;
        seen = 0;
        prev = scl_o;
        for (int k = 0; k < 400 && seen < 3; k++) begin
          @(posedge clk); #1;
          if (scl_o && !prev) seen++;
          prev = scl_o;
        end
        stretch = 1'b1;
        repeat (10) @(posedge clk);
        #1 stretch = 1'b0;
      end
    join
    check("t5_wr_lat", r_lat, 36*D+11);
    check("t5_ack", {31'd0, r_ack}, 32'd1);
    check("t5_restart", n_restart - rs0, 1);
    do_cmd(CmdStop, 8'h00, 1'b0);

    // Asynchronous reset during slot 3 of a WRITE
    do_cmd(CmdStart, 8'h00, 1'b0);
    cmd_r = CmdWrite; wdata = 8'h44; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (12*D + 1) @(posedge clk);
    #3;
    check("t6_pre_scl", {31'd0, scl_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rel_lines", {30'd0, scl_o, sda_o}, 32'd3);
    check("t6_owned", {31'd0, bus_owned_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("t6_data_clr", {24'd0, rsp_data_o}, 32'h00);

    // Randomized write/read traffic against queue model
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 3);
      sl_rx.delete(); exp_q.delete();
      do_cmd(CmdStart, 8'h00, 1'b0);
      do_cmd(CmdWrite, 8'h44, 1'b0);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        do_cmd(CmdWrite, b, 1'b0);
        check("rnd_wr_ack", {31'd0, r_ack}, 32'd1);
      end
      do_cmd(CmdStop, 8'h00, 1'b0);
      check("rnd_rx_len", sl_rx.size(), n);
      for (int i = 0; i < n && i < sl_rx.size(); i++)
        check("rnd_rx_byte", {24'd0, sl_rx[i]}, {24'd0, exp_q[i]});

      m = $urandom_range(1, 3);
      sl_tx.delete(); exp_q.delete();
      for (int i = 0; i < m; i++) begin
        b = 8'($urandom);
        sl_tx.push_back(b);
        exp_q.push_back(b);
      end
      do_cmd(CmdStart, 8'h00, 1'b0);
      do_cmd(CmdWrite, 8'h45, 1'b0);
      for (int i = 0; i < m; i++) begin
        do_cmd(CmdRead, 8'h00, (i == m - 1));
        check("rnd_rd_data", {24'd0, r_data}, {24'd0, exp_q[i]});
        check("rnd_rd_acksda", {31'd0, ack_sda}, (i == m - 1) ? 32'd1 : 32'd0);
      end
      do_cmd(CmdStop, 8'h00, 1'b0);

      ic = 2'($urandom_range(1, 3));
      do_cmd(ic, 8'($urandom), 1'b0);
      check("rnd_illegal_err", {31'd0, r_err}, 32'd1);
      check("rnd_illegal_lat", r_lat, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
